// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b, LSB first, one bit per clock.
// Latency: done appears WIDTH+1 cycles after the accepting edge, one
// result every WIDTH+2 cycles when start is held high.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  // One full-subtractor slice on the current operand LSBs
  logic             a0, b0, d_bit, br_nx, last;
  logic [WIDTH-1:0] res_d;

  assign a0    = a_q[0];
  assign b0    = b_q[0];
  assign d_bit = a0 ^ b0 ^ br_q;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign last  = (cnt_q == CW'(WIDTH - 1));
  assign res_d = {d_bit, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  // Operand capture, serial datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          br_q  <= 1'b0;
          cnt_q <= '0;
        end
        SHIFT: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_nx;
          cnt_q <= cnt_q + CW'(1);
          // Publish only the completed word; partial bits stay internal
          if (last) begin
            diff_q <= res_d;
            bout_q <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
            // On the last step a0/b0 are the original sign bits
            ovf_q  <= (a0 != b0) && (d_bit != a0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed vectors for serial_sub at WIDTH=8.
// Define SERIAL_SUB_OVF_EN for both files to also check ovf.
module tb_serial_sub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc    = 0;
  logic [W-1:0] prev_diff;

  serial_sub_if #(.WIDTH(W)) bus ();
  serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) n_done <= n_done + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Wait (at negedges) for done; lat counts cycles since the accepting edge
  task automatic wait_done(inout int lat);
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string tag);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
    lat = 1;
    chk({tag, "_busy"}, bus.busy, 1);
    while (!bus.done && lat < 30) begin
      if (lat == 4) chk({tag, "_hold"}, bus.diff, prev_diff);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, W + 1);
    chk({tag, "_diff"}, bus.diff, ed);
    chk({tag, "_bout"}, bus.bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, bus.ovf, eo);
`endif
    @(negedge clk);
    chk({tag, "_pulse"}, {bus.done, bus.busy}, 2'b00);
    prev_diff = ed;
  endtask

  initial begin
    logic [W-1:0] opa [3];
    logic [W-1:0] opb [3];
    logic [W-1:0] exd [3];
    logic         exb [3];
    logic         exo [3];
    int lat, nd0, t_prev, t_now;

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {bus.busy, bus.done, bus.diff, bus.bout}, '0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    rst = 1'b0;
    prev_diff = '0;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub_05_03");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_03_05");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, "sub_eq");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "sub_00_FF");

    // Second start during SHIFT must be ignored
    nd0 = n_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h20; bus.b = 8'h07;
    @(negedge clk);
    bus.start = 1'b0; lat = 1;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    bus.start = 1'b0;
    wait_done(lat);
    chk("ign_lat", lat, W + 1);
    chk("ign_diff", bus.diff, 8'h19);
    chk("ign_bout", bus.bout, 0);
    repeat (15) @(negedge clk);
    chk("ign_ndone", n_done - nd0, 1);
    prev_diff = 8'h19;

    // Reset in the 4th SHIFT cycle aborts without a done pulse
    nd0 = n_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_diff", bus.diff, 8'h00);
    chk("abort_bout", bus.bout, 0);
    repeat (12) @(negedge clk);
    chk("abort_ndone", n_done - nd0, 0);
    prev_diff = '0;
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "after_rst");

    // Start held high: back-to-back operations every W+2 cycles
    opa[0] = 8'h44; opb[0] = 8'h11; exd[0] = 8'h33; exb[0] = 1'b0; exo[0] = 1'b0;
    opa[1] = 8'h01; opb[1] = 8'h02; exd[1] = 8'hFF; exb[1] = 1'b1; exo[1] = 1'b0;
    opa[2] = 8'h7F; opb[2] = 8'hFF; exd[2] = 8'h80; exb[2] = 1'b1; exo[2] = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.a = opa[0]; bus.b = opb[0];
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      @(negedge clk);
      wait_done(lat);
      t_now = cyc;
      chk($sformatf("b2b%0d_diff", k), bus.diff, exd[k]);
      chk($sformatf("b2b%0d_bout", k), bus.bout, exb[k]);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("b2b%0d_ovf", k), bus.ovf, exo[k]);
`endif
      if (k > 0) chk($sformatf("b2b%0d_gap", k), t_now - t_prev, W + 2);
      t_prev = t_now;
      if (k < 2) begin
        bus.a = opa[k+1]; bus.b = opb[k+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("b2b_idle", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction, sampled on the rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress (SHIFT or DONE state).
REQ-008 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking a valid new result.
REQ-009 The block SHALL have port diff, output, WIDTH bits, the registered result a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit, the registered final borrow (1 when a < b as unsigned values).

Function
REQ-011 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 IDLE: start=1 at an edge SHALL latch a and b into operand shift registers, clear the borrow flip-flop and bit counter, and go to SHIFT.
REQ-013 SHIFT SHALL process one bit per cycle, LSB first: d = a0^b0^br, br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-014 Each SHIFT cycle SHALL shift d into the MSB of an internal result register, shift both operands right by one, and increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles the block SHALL go to DONE.
REQ-016 On entry to DONE, diff SHALL load the internal result register and bout the final borrow.
REQ-017 done SHALL be high for exactly that DONE cycle, after which the block SHALL return to IDLE.
REQ-018 The done pulse SHALL occur WIDTH+1 cycles after the edge that accepted start.
REQ-019 start SHALL be ignored while busy=1; a and b SHALL be don't-care outside the accepting edge.
REQ-020 diff and bout SHALL hold their last value until the next DONE entry; in-progress bits SHALL never be visible on diff.
REQ-021 start held high continuously SHALL start a new operation on the first IDLE edge after each DONE, giving one result every WIDTH+2 cycles.
REQ-022 a = b SHALL give diff = 0 and bout = 0; a = 0 with b = all-ones SHALL give diff = 1 and bout = 1.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and clear the operand registers, result register, counter and borrow flip-flop; busy, done, diff and bout SHALL all become 0.
REQ-024 rst SHALL take priority over start and over an operation in progress; the aborted operation SHALL produce no done pulse.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN SHALL control a signed-overflow output.
REQ-026 With SERIAL_SUB_OVF_EN defined, the block SHALL add port ovf, output, 1 bit.
REQ-027 ovf SHALL load together with diff, with value (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), reset to 0, and be held like diff.
REQ-028 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 Bench SHALL cover: start with a=0x05, b=0x03 -> done 9 cycles later, diff=0x02, bout=0 (ovf=0).
REQ-030 Bench SHALL cover: a=0x03, b=0x05 -> diff=0xFE, bout=1 (ovf=0).
REQ-031 Bench SHALL cover: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1 when SERIAL_SUB_OVF_EN is defined.
REQ-032 Bench SHALL cover: second start pulse with a=0xFF, b=0x00 during SHIFT -> ignored; first result returned, exactly one done pulse.
REQ-033 Bench SHALL cover: rst asserted in the 4th SHIFT cycle -> next cycle busy=0, diff=0x00, bout=0, no done pulse; a following start with a=0x10, b=0x01 gives diff=0x0F.
REQ-034 Bench SHALL cover: start held high for three operations -> done pulses exactly 10 cycles apart, each result correct.
